// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, symbol codes, element timing and ROM entry type.
package morse_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_GAP, ST_CHAR_GAP} state_t;

    localparam logic [5:0] SYM_A = 6'd0,  SYM_B = 6'd1,  SYM_C = 6'd2,  SYM_D = 6'd3,
                           SYM_E = 6'd4,  SYM_F = 6'd5,  SYM_G = 6'd6,  SYM_H = 6'd7,
                           SYM_I = 6'd8,  SYM_J = 6'd9,  SYM_K = 6'd10, SYM_L = 6'd11,
                           SYM_M = 6'd12, SYM_N = 6'd13, SYM_O = 6'd14, SYM_P = 6'd15,
                           SYM_Q = 6'd16, SYM_R = 6'd17, SYM_S = 6'd18, SYM_T = 6'd19,
                           SYM_U = 6'd20, SYM_V = 6'd21, SYM_W = 6'd22, SYM_X = 6'd23,
                           SYM_Y = 6'd24, SYM_Z = 6'd25;
    localparam logic [5:0] SYM_0 = 6'd26, SYM_1 = 6'd27, SYM_2 = 6'd28, SYM_3 = 6'd29,
                           SYM_4 = 6'd30, SYM_5 = 6'd31, SYM_6 = 6'd32, SYM_7 = 6'd33,
                           SYM_8 = 6'd34, SYM_9 = 6'd35;
    localparam logic [5:0] SYM_SPACE = 6'd36;
    localparam logic [5:0] SYM_MAX   = SYM_9;

    localparam logic [2:0] DOT_UNITS      = 3'd1;
    localparam logic [2:0] DASH_UNITS     = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

    // pat is sent LSB first, 1 = dash
    typedef struct packed {
        logic       valid;
        logic       space;
        logic [2:0] len;
        logic [4:0] pat;
    } rom_ent_t;

    function automatic rom_ent_t mk_ent(input logic [2:0] l, input logic [4:0] p);
        return '{valid: 1'b1, space: 1'b0, len: l, pat: p};
    endfunction

endpackage

// File: rtl/morse_code_rom.sv
// Combinational symbol-code to Morse pattern lookup.
// MORSE_WORD_GAP_EN makes SYM_SPACE a valid (silent) entry.
module morse_code_rom
    import morse_pkg::*;
(
    input  logic [5:0] sym_code,
    output rom_ent_t   ent
);

    always_comb begin
        ent = '0;
        case (sym_code)
            SYM_A: ent = mk_ent(3'd2, 5'b00010);
            SYM_B: ent = mk_ent(3'd4, 5'b00001);
            SYM_C: ent = mk_ent(3'd4, 5'b00101);
            SYM_D: ent = mk_ent(3'd3, 5'b00001);
            SYM_E: ent = mk_ent(3'd1, 5'b00000);
            SYM_F: ent = mk_ent(3'd4, 5'b00100);
            SYM_G: ent = mk_ent(3'd3, 5'b00011);
            SYM_H: ent = mk_ent(3'd4, 5'b00000);
            SYM_I: ent = mk_ent(3'd2, 5'b00000);
            SYM_J: ent = mk_ent(3'd4, 5'b01110);
            SYM_K: ent = mk_ent(3'd3, 5'b00101);
            SYM_L: ent = mk_ent(3'd4, 5'b00010);
            SYM_M: ent = mk_ent(3'd2, 5'b00011);
            SYM_N: ent = mk_ent(3'd2, 5'b00001);
            SYM_O: ent = mk_ent(3'd3, 5'b00111);
            SYM_P: ent = mk_ent(3'd4, 5'b00110);
            SYM_Q: ent = mk_ent(3'd4, 5'b01011);
            SYM_R: ent = mk_ent(3'd3, 5'b00010);
            SYM_S: ent = mk_ent(3'd3, 5'b00000);
            SYM_T: ent = mk_ent(3'd1, 5'b00001);
            SYM_U: ent = mk_ent(3'd3, 5'b00100);
            SYM_V: ent = mk_ent(3'd4, 5'b01000);
            SYM_W: ent = mk_ent(3'd3, 5'b00110);
            SYM_X: ent = mk_ent(3'd4, 5'b01001);
            SYM_Y: ent = mk_ent(3'd4, 5'b01101);
            SYM_Z: ent = mk_ent(3'd4, 5'b00011);
            SYM_0: ent = mk_ent(3'd5, 5'b11111);
            SYM_1: ent = mk_ent(3'd5, 5'b11110);
            SYM_2: ent = mk_ent(3'd5, 5'b11100);
            SYM_3: ent = mk_ent(3'd5, 5'b11000);
            SYM_4: ent = mk_ent(3'd5, 5'b10000);
            SYM_5: ent = mk_ent(3'd5, 5'b00000);
            SYM_6: ent = mk_ent(3'd5, 5'b00001);
            SYM_7: ent = mk_ent(3'd5, 5'b00011);
            SYM_8: ent = mk_ent(3'd5, 5'b00111);
            SYM_9: ent = mk_ent(3'd5, 5'b01111);
`ifdef MORSE_WORD_GAP_EN
            SYM_SPACE: ent = '{valid: 1'b1, space: 1'b1, len: 3'd0, pat: 5'b00000};
`else
            SYM_SPACE: ent = '0;
`endif
            default: ent = '0;
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one symbol code per handshake and keys dots, dashes and ITU gaps.
// MORSE_WORD_GAP_EN (in morse_code_rom) enables the 7-unit word space on SYM_SPACE.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sym_code,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       key,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cyc;
    logic [2:0]    unit, idx, len_q, cur_dur;
    logic [4:0]    pat_q;
    logic          word_q;
    logic          tick, state_end, pre_end;
    rom_ent_t      rom;

    morse_code_rom u_rom (
        .sym_code (sym_code),
        .ent      (rom)
    );

    always_comb begin
        cur_dur = DOT_UNITS;
        case (state)
            ST_MARK:     cur_dur = pat_q[idx] ? DASH_UNITS : DOT_UNITS;
            ST_GAP:      cur_dur = ELEM_GAP_UNITS;
            ST_CHAR_GAP: cur_dur = word_q ? WORD_GAP_UNITS : CHAR_GAP_UNITS;
            default:     cur_dur = DOT_UNITS;
        endcase
    end

    assign tick      = (cyc == CYC_LAST);
    assign state_end = tick && (unit == cur_dur - 3'd1);
    // Lookahead: the coming cycle is the final one of the current state, so done can be registered
    assign pre_end   = tick ? ((CYC_LAST == '0) && (3'(unit + 3'd1) == cur_dur - 3'd1))
                            : ((CW'(cyc + 1'b1) == CYC_LAST) && (unit == cur_dur - 3'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cyc       <= '0;
            unit      <= '0;
            idx       <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            word_q    <= 1'b0;
            key       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sym_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cyc  <= '0;
                    unit <= '0;
                    if (sym_valid) begin
                        if (rom.valid) begin
                            len_q     <= rom.len;
                            pat_q     <= rom.pat;
                            word_q    <= rom.space;
                            idx       <= '0;
                            state     <= rom.space ? ST_CHAR_GAP : ST_MARK;
                            key       <= !rom.space;
                            busy      <= 1'b1;
                            sym_ready <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (state_end) begin
                        cyc  <= '0;
                        unit <= '0;
                        case (state)
                            ST_MARK: begin
                                key <= 1'b0;
                                if (3'(idx + 3'd1) < len_q) begin
                                    state <= ST_GAP;
                                    idx   <= 3'(idx + 3'd1);
                                end else begin
                                    state <= ST_CHAR_GAP;
                                end
                            end
                            ST_GAP: begin
                                state <= ST_MARK;
                                key   <= 1'b1;
                            end
                            default: begin
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                                sym_ready <= 1'b1;
                            end
                        endcase
                    end else begin
                        cyc  <= tick ? '0 : CW'(cyc + 1'b1);
                        unit <= tick ? 3'(unit + 3'd1) : unit;
                        done <= (state == ST_CHAR_GAP) && pre_end;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: a dot/dash string model pushes per-cycle expectations.
module tb_morse_encoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] sym_code;
    logic       sym_valid;
    logic       sym_ready, key, busy, done, err;

    int total = 0;
    int bad   = 0;

    // expected per-cycle {key, done, err, sym_ready, busy}
    logic [4:0] q[$];
    localparam logic [4:0] E_IDLE = 5'b00010;
    localparam logic [4:0] E_ERR  = 5'b00110;
    localparam logic [4:0] E_MARK = 5'b10001;
    localparam logic [4:0] E_SIL  = 5'b00001;
    localparam logic [4:0] E_DONE = 5'b01001;

    string tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                       "---..", "----."};

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_code  (sym_code),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic bit word_gap_en();
`ifdef MORSE_WORD_GAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: expand the dot/dash text into one expected entry per clock after acceptance
    task automatic push_model(input int code);
        string s;
        if (code < 36) begin
            s = tab[code];
            for (int i = 0; i < s.len(); i++) begin
                for (int c = 0; c < ((s[i] == "-") ? 3 : 1) * U; c++) q.push_back(E_MARK);
                if (i < s.len() - 1)
                    for (int c = 0; c < U; c++) q.push_back(E_SIL);
            end
            for (int c = 0; c < 3 * U - 1; c++) q.push_back(E_SIL);
            q.push_back(E_DONE);
        end else if (code == 36 && word_gap_en()) begin
            for (int c = 0; c < 7 * U - 1; c++) q.push_back(E_SIL);
            q.push_back(E_DONE);
        end else begin
            q.push_back(E_ERR);
        end
    endtask

    // Monitor: one comparison per cycle, sampled just after the active edge
    initial begin
        logic [4:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            e = (q.size() > 0) ? q.pop_front() : E_IDLE;
            a = {key, done, err, sym_ready, busy};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle_check t=%0t got key,done,err,rdy,busy=%b want %b", $time, a, e);
            end
        end
    end

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Called and returns at a negedge; leaves sym_valid low so a following call holds it high
    task automatic send(input int code);
        int n;
        sym_code  = 6'(code);
        sym_valid = 1'b1;
        n = 0;
        while (!sym_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout code=%0d got ready=0 want ready=1", code);
        end else begin
            push_model(code);
        end
        @(negedge clk);
        sym_valid = 1'b0;
        sym_code  = 6'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int code;
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym_code  = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {key, done, err, sym_ready, busy}, E_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(4);  drain();              // E
        send(0);  drain();              // A
        send(19); send(26); drain();    // T then 0, valid held
        send(45); drain();              // invalid
        send(36); drain();              // word space or invalid
        send(63); send(7); drain();     // invalid followed immediately by H

        for (int i = 0; i < 40; i++) begin
            code = ($urandom_range(0, 7) == 0) ? int'($urandom_range(36, 63))
                                               : int'($urandom_range(0, 35));
            send(code);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // Reset on the 6th cycle of T's dash
        send(19);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_dash", {key, done, err, sym_ready, busy}, E_IDLE);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        send(5); drain();               // F after recovery

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
